ir_fetch: RTL and testbench

Instruction fetch and instruction-register stage that sits directly upstream of the CPU control state machine. It owns the program counter and drives the ROM address. On the controller's `fetch` strobe it assembles each two-byte ROM instruction into the 3-bit opcode `ins` consumed by the controller, plus a 13-bit operand address. It is a pure datapath/sequencer slave: all timing is dictated by `PC_en` and `fetch` from the controller.

---
 rtl/ir_fetch.sv | 98 +++++++++
 tb/tb_ir_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch.sv
// Instruction fetch / instruction register: owns the PC and assembles two-byte ROM instructions.
// Optional odd-parity checking of captured bytes is enabled by defining IR_PARITY_EN.
module ir_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_en,
  input  logic [1:0]        fetch,
  input  logic              ld_pc,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] rom_data,
`ifdef IR_PARITY_EN
  input  logic              rom_par,
  output logic              par_err,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        ins,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              ir_valid,
  output logic              fetch_err,
  output logic [15:0]       instr_cnt
);

  typedef enum logic [1:0] {HI, LO, FULL} byte_state_e;

  byte_state_e       state_q, state_d;
  logic              cap_hi, cap_lo, set_err;
  logic [ADDR_W-1:0] pc;

  assign rom_addr = pc;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cap_hi  = 1'b0;
    cap_lo  = 1'b0;
    set_err = 1'b0;
    case (fetch)
      2'b01: begin
        case (state_q)
          HI: begin
            cap_hi  = 1'b1;
            state_d = LO;
          end
          LO: begin
            cap_lo  = 1'b1;
            state_d = FULL;
          end
          default: set_err = 1'b1;  // a third capture is a controller fault
        endcase
      end
      2'b10:   state_d = HI;
      2'b11:   set_err = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HI;
      pc        <= '0;
      ins       <= 3'b000;
      ir_addr   <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      instr_cnt <= 16'd0;
    end else begin
      state_q <= state_d;

      if (ld_pc)      pc <= ld_addr;
      else if (PC_en) pc <= pc + ADDR_W'(1);

      if (cap_hi) begin
        ins                     <= rom_data[DATA_W-1:DATA_W-3];
        ir_addr[ADDR_W-1:DATA_W] <= rom_data[ADDR_W-DATA_W-1:0];
        ir_valid                <= 1'b0;
      end
      if (cap_lo) begin
        ir_addr[DATA_W-1:0] <= rom_data;
        ir_valid            <= 1'b1;
        instr_cnt           <= instr_cnt + 16'd1;
      end
      if (set_err) fetch_err <= 1'b1;
    end
  end

`ifdef IR_PARITY_EN
  // Odd parity over byte plus parity bit; the byte is stored regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              par_err <= 1'b0;
    else if ((cap_hi || cap_lo) && !(^{rom_data, rom_par})) par_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ir_fetch.sv
// Directed self-checking bench for ir_fetch; parity checks compile in when IR_PARITY_EN is defined.
module tb_ir_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_en;
  logic [1:0]  fetch;
  logic        ld_pc;
  logic [12:0] ld_addr;
  logic [7:0]  rom_data;
  logic [12:0] rom_addr;
  logic [2:0]  ins;
  logic [12:0] ir_addr;
  logic        ir_valid;
  logic        fetch_err;
  logic [15:0] instr_cnt;
`ifdef IR_PARITY_EN
  logic        rom_par;
  logic        par_err;
`endif

  int total = 0;
  int bad   = 0;

  ir_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .PC_en    (PC_en),
    .fetch    (fetch),
    .ld_pc    (ld_pc),
    .ld_addr  (ld_addr),
    .rom_data (rom_data),
`ifdef IR_PARITY_EN
    .rom_par  (rom_par),
    .par_err  (par_err),
`endif
    .rom_addr (rom_addr),
    .ins      (ins),
    .ir_addr  (ir_addr),
    .ir_valid (ir_valid),
    .fetch_err(fetch_err),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rom_addr"},  32'(rom_addr),  0);
    check({tag, ".ins"},       32'(ins),       0);
    check({tag, ".ir_addr"},   32'(ir_addr),   0);
    check({tag, ".ir_valid"},  32'(ir_valid),  0);
    check({tag, ".fetch_err"}, 32'(fetch_err), 0);
    check({tag, ".instr_cnt"}, 32'(instr_cnt), 0);
  endtask

  initial begin
    rst = 1'b1; PC_en = 1'b0; fetch = 2'b00; ld_pc = 1'b0; ld_addr = '0; rom_data = '0;
`ifdef IR_PARITY_EN
    rom_par = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    step();
    check_reset_vals("reset");

    // First byte with a PC increment in the same cycle.
    fetch = 2'b01; rom_data = 8'hA5; PC_en = 1'b1;
    step();
    check("hi.ins",      32'(ins),      'h5);
    check("hi.ir_addr",  32'(ir_addr),  'h0500);
    check("hi.ir_valid", 32'(ir_valid), 0);
    check("hi.rom_addr", 32'(rom_addr), 'h1);
    PC_en = 1'b0; rom_data = 8'h3C;
    step();
    check("lo.ir_addr",   32'(ir_addr),   'h053C);
    check("lo.ir_valid",  32'(ir_valid),  1);
    check("lo.instr_cnt", 32'(instr_cnt), 1);

    // Third capture is an error and must not disturb the held instruction.
    rom_data = 8'hFF;
    step();
    check("full.fetch_err", 32'(fetch_err), 1);
    check("full.ir_addr",   32'(ir_addr),   'h053C);
    check("full.instr_cnt", 32'(instr_cnt), 1);

    fetch = 2'b10;
    step();
    check("end.ins",      32'(ins),      'h5);
    check("end.ir_valid", 32'(ir_valid), 1);
    fetch = 2'b01; rom_data = 8'hE0;
    step();
    check("next.ins",      32'(ins),      'h7);
    check("next.ir_valid", 32'(ir_valid), 0);
    check("next.ir_addr",  32'(ir_addr),  'h003C);
    fetch = 2'b00; rom_data = 8'h55;
    step();
    check("hold.ir_addr", 32'(ir_addr), 'h003C);

    // PC: load, wrap, load priority over increment, hold.
    ld_pc = 1'b1; ld_addr = 13'h1FFF;
    step();
    check("pc.load", 32'(rom_addr), 'h1FFF);
    ld_pc = 1'b0; PC_en = 1'b1;
    step();
    check("pc.wrap", 32'(rom_addr), 'h0000);
    ld_pc = 1'b1; ld_addr = 13'h0100;
    step();
    check("pc.ld_prio", 32'(rom_addr), 'h0100);
    ld_pc = 1'b0; PC_en = 1'b0;
    step();
    check("pc.hold", 32'(rom_addr), 'h0100);

    // Jump together with the low-byte capture (FSM is in LO here).
    fetch = 2'b01; rom_data = 8'h42; ld_pc = 1'b1; ld_addr = 13'h0ABC;
    step();
    check("ldcap.ir_addr",   32'(ir_addr),   'h0042);
    check("ldcap.instr_cnt", 32'(instr_cnt), 2);
    check("ldcap.rom_addr",  32'(rom_addr),  'h0ABC);
    ld_pc = 1'b0;

    // Asynchronous reset while in LO.
    fetch = 2'b10;
    step();
    fetch = 2'b01; rom_data = 8'h21;
    step();
    check("midlo.ins", 32'(ins), 'h1);
    fetch = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    #3 rst = 1'b0;
    step();
    check("post_rst.instr_cnt", 32'(instr_cnt), 0);

    // Illegal fetch code: flag only, state untouched.
    fetch = 2'b11; rom_data = 8'h99;
    step();
    check("ill.fetch_err", 32'(fetch_err), 1);
    check("ill.ins",       32'(ins),       0);
    fetch = 2'b01; rom_data = 8'h81;
    step();
    check("ill_hi.ins", 32'(ins), 'h4);
    rom_data = 8'h7F;
    step();
    check("ill_lo.ir_addr",   32'(ir_addr),   'h017F);
    check("ill_lo.instr_cnt", 32'(instr_cnt), 1);
    check("ill_lo.fetch_err", 32'(fetch_err), 1);

`ifdef IR_PARITY_EN
    fetch = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("par.reset", 32'(par_err), 0);
    fetch = 2'b01; rom_data = 8'h01; rom_par = 1'b0;
    step();
    check("par.good", 32'(par_err), 0);
    rom_data = 8'h03;
    step();
    check("par.bad",       32'(par_err), 1);
    check("par.stored",    32'(ir_addr), 'h0103);
    fetch = 2'b10;
    step();
    fetch = 2'b01; rom_data = 8'h01;
    step();
    check("par.sticky", 32'(par_err), 1);
    fetch = 2'b00;
    rst = 1'b1;
    #1;
    check("par.cleared", 32'(par_err), 0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
